// File: rtl/tone_gen_pkg.sv
// Shared definitions for the tone generator: pitch table, half-period helper,
// envelope state type and level limit.
package tone_gen_pkg;

  // Equal-tempered pitches C4..B5 in millihertz.
  localparam int F_MHZ [0:23] = '{
    261626, 277183, 293665, 311127, 329628, 349228,
    369994, 391995, 415305, 440000, 466164, 493883,
    523251, 554365, 587330, 622254, 659255, 698456,
    739989, 783991, 830609, 880000, 932328, 987767
  };

  localparam logic [3:0] LEVEL_MAX = 4'd15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } env_state_t;

  // Clock cycles per half period of key k; out-of-table keys get all ones.
  function automatic logic [19:0] half_period(input longint clk_freq, input int k);
    longint q;
    if (k < 0 || k > 23) return '1;
    q = (clk_freq * 64'd500) / longint'(F_MHZ[k]);
    return q[19:0];
  endfunction

endpackage

// File: rtl/tone_env.sv
// Attack/sustain/release envelope: free-running step tick, state machine and
// 4-bit level. Also flags note start and note end for the oscillator.
module tone_env
  import tone_gen_pkg::*;
#(
  parameter int ENV_DIV = 65536
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vpress,
  output logic [3:0] level,
  output logic       playing,
  output logic       start,
  output logic       stop
);

  localparam int TW = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(ENV_DIV - 1);

  env_state_t    state;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [3:0]    rel_level;

  assign tick = (tick_cnt == TICK_LAST);

  // Free-running step divider, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TW'(1);
  end

  // Release-phase level after this cycle's tick, and note start/end strobes.
  always_comb begin
    rel_level = level;
    if (tick && level != 4'd0) rel_level = level - 4'd1;
    start = (state == IDLE) && vpress;
    stop  = (state == RELEASE) && !vpress && (rel_level == 4'd0);
  end

  // Envelope state machine; a dropped press beats a same-cycle attack tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      level   <= 4'd0;
      playing <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (vpress) begin
            state   <= ATTACK;
            playing <= 1'b1;
          end
        end
        ATTACK: begin
          if (!vpress) begin
            state <= RELEASE;
          end else if (level == LEVEL_MAX) begin
            state <= SUSTAIN;
          end else if (tick) begin
            level <= level + 4'd1;
            if (level == LEVEL_MAX - 4'd1) state <= SUSTAIN;
          end
        end
        SUSTAIN: begin
          level <= LEVEL_MAX;
          if (!vpress) state <= RELEASE;
        end
        RELEASE: begin
          level <= rel_level;
          if (vpress) begin
            state <= ATTACK;
          end else if (rel_level == 4'd0) begin
            state   <= IDLE;
            playing <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          level   <= 4'd0;
          playing <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/tone_gen.sv
// Key-driven square-wave tone generator with envelope-shaped PWM output.
// Optional octave shift input is enabled by defining TONE_GEN_OCTAVE_EN.
module tone_gen
  import tone_gen_pkg::*;
#(
  parameter int NUM_KEYS = 24,
  parameter int CLK_FREQ = 50000000,
  parameter int ENV_DIV  = 65536
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] key,
  input  logic       press,
`ifdef TONE_GEN_OCTAVE_EN
  input  logic [1:0] octave,
`endif
  output logic       audio_out,
  output logic       playing,
  output logic [3:0] level
);

  localparam logic [5:0] KEY_LIMIT = 6'(NUM_KEYS);

  logic [19:0] hp_rom [0:31];
  logic        vpress;
  logic        env_start;
  logic        env_stop;
  logic        phase;
  logic [19:0] cnt;
  logic [4:0]  cur_key;
  logic [4:0]  pending_key;
  logic [4:0]  cur_key_next;
  logic        phase_edge;
  logic [3:0]  pwm_cnt;
  logic [1:0]  oct_in;
  logic [1:0]  cur_oct_next;

  // Half-period table; unused indices hold all ones and are never selected.
  for (genvar gi = 0; gi < 32; gi++) begin : g_hp
    if (gi < NUM_KEYS) begin : g_valid
      assign hp_rom[gi] = half_period(longint'(CLK_FREQ), gi);
    end else begin : g_pad
      assign hp_rom[gi] = '1;
    end
  end

  assign vpress = press && ({1'b0, key} < KEY_LIMIT);

  tone_env #(
    .ENV_DIV(ENV_DIV)
  ) u_env (
    .clk    (clk),
    .rst_n  (rst_n),
    .vpress (vpress),
    .level  (level),
    .playing(playing),
    .start  (env_start),
    .stop   (env_stop)
  );

`ifdef TONE_GEN_OCTAVE_EN
  logic [1:0] pending_oct;
  logic [1:0] cur_oct;

  assign oct_in       = (octave == 2'd3) ? 2'd2 : octave;
  assign cur_oct_next = phase_edge ? pending_oct : cur_oct;

  // Octave follows the key: captured with it, applied only at a phase edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_oct <= 2'd0;
      cur_oct     <= 2'd0;
    end else begin
      if (vpress) pending_oct <= oct_in;
      if (env_start) cur_oct <= oct_in;
      else           cur_oct <= cur_oct_next;
    end
  end
`else
  assign oct_in       = 2'd0;
  assign cur_oct_next = 2'd0;
`endif

  // The sounding key only changes at a square-wave edge.
  always_comb begin
    phase_edge   = playing && (cnt == 20'd0);
    cur_key_next = phase_edge ? pending_key : cur_key;
  end

  // Half-period counter and square-wave phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase       <= 1'b0;
      cnt         <= 20'd0;
      cur_key     <= 5'd0;
      pending_key <= 5'd0;
    end else begin
      if (vpress) pending_key <= key;
      if (env_start) begin
        phase   <= 1'b1;
        cnt     <= (hp_rom[key] >> oct_in) - 20'd1;
        cur_key <= key;
      end else if (env_stop) begin
        phase <= 1'b0;
        cnt   <= 20'd0;
      end else if (phase_edge) begin
        phase   <= ~phase;
        cnt     <= (hp_rom[cur_key_next] >> cur_oct_next) - 20'd1;
        cur_key <= cur_key_next;
      end else if (playing) begin
        cnt <= cnt - 20'd1;
      end
    end
  end

  // PWM: high for `level` of every 16 cycles while the square wave is high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt   <= 4'd0;
      audio_out <= 1'b0;
    end else begin
      pwm_cnt   <= pwm_cnt + 4'd1;
      audio_out <= phase & (pwm_cnt < level);
    end
  end

endmodule

// File: tb/tb_tone_gen.sv
// Self-checking bench for tone_gen: directed scenarios followed by random
// key/press activity, compared every cycle against a behavioural model.
module tb_tone_gen;

  localparam int CLK_FREQ = 1000000;
  localparam int ENV_DIV  = 4;
  localparam int NUM_KEYS = 24;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       press = 1'b0;
  logic [4:0] key   = 5'd0;
  logic       audio_out;
  logic       playing;
  logic [3:0] level;
`ifdef TONE_GEN_OCTAVE_EN
  logic [1:0] octave = 2'd0;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tone_gen #(
    .NUM_KEYS(NUM_KEYS),
    .CLK_FREQ(CLK_FREQ),
    .ENV_DIV (ENV_DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key      (key),
    .press    (press),
`ifdef TONE_GEN_OCTAVE_EN
    .octave   (octave),
`endif
    .audio_out(audio_out),
    .playing  (playing),
    .level    (level)
  );

  // ---------------- reference model ----------------
  int ref_mhz [0:23] = '{
    261626, 277183, 293665, 311127, 329628, 349228,
    369994, 391995, 415305, 440000, 466164, 493883,
    523251, 554365, 587330, 622254, 659255, 698456,
    739989, 783991, 830609, 880000, 932328, 987767
  };

  string m_mode     = "IDLE";
  int    m_level    = 0;
  int    m_phase    = 0;
  int    m_remain   = 0;
  int    m_pend     = 0;
  int    m_pend_oct = 0;
  int    m_age      = 0;
  int    m_audio    = 0;

  function automatic int ref_half(int k, int oct);
    longint num;
    int     o;
    o   = (oct > 2) ? 2 : oct;
    num = longint'(CLK_FREQ) * 500;
    return int'(num / longint'(ref_mhz[k])) / (1 << o);
  endfunction

  function automatic int oct_now();
`ifdef TONE_GEN_OCTAVE_EN
    return int'(octave);
`else
    return 0;
`endif
  endfunction

  task automatic model_edge();
    bit    vp, tick;
    string nmode;
    int    nlevel, nphase, nremain;
    if (!rst_n) begin
      m_mode = "IDLE"; m_level = 0; m_phase = 0; m_remain = 0;
      m_pend = 0; m_pend_oct = 0; m_age = 0; m_audio = 0;
      return;
    end
    vp   = press && (int'(key) < NUM_KEYS);
    tick = (m_age % ENV_DIV) == ENV_DIV - 1;
    m_audio = (m_phase == 1 && (m_age % 16) < m_level) ? 1 : 0;
    nmode = m_mode; nlevel = m_level; nphase = m_phase; nremain = m_remain;
    if (m_mode == "IDLE") begin
      if (vp) begin
        nmode = "ATTACK"; nphase = 1; nremain = ref_half(int'(key), oct_now());
      end
    end else if (m_mode == "ATTACK") begin
      if (!vp) nmode = "RELEASE";
      else if (m_level == 15) nmode = "SUSTAIN";
      else if (tick) begin
        nlevel = m_level + 1;
        if (nlevel == 15) nmode = "SUSTAIN";
      end
    end else if (m_mode == "SUSTAIN") begin
      nlevel = 15;
      if (!vp) nmode = "RELEASE";
    end else begin
      if (tick && m_level > 0) nlevel = m_level - 1;
      if (vp) nmode = "ATTACK";
      else if (nlevel == 0) begin
        nmode = "IDLE"; nphase = 0; nremain = 0;
      end
    end
    if (m_mode != "IDLE" && nmode != "IDLE") begin
      if (m_remain == 1) begin
        nphase  = 1 - m_phase;
        nremain = ref_half(m_pend, m_pend_oct);
      end else begin
        nremain = m_remain - 1;
      end
    end
    if (vp) begin
      m_pend = int'(key); m_pend_oct = oct_now();
    end
    m_mode = nmode; m_level = nlevel; m_phase = nphase; m_remain = nremain;
    m_age++;
  endtask

  // ---------------- checking ----------------
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("audio_out", 32'(audio_out), 32'(m_audio));
    chk("level", 32'(level), 32'(m_level));
    chk("playing", 32'(playing), (m_mode != "IDLE") ? 32'd1 : 32'd0);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    // Reset held with a valid press pending
    rst_n = 1'b0; press = 1'b1; key = 5'd5;
    run(3);
    chk("rst_playing", 32'(playing), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_audio", 32'(audio_out), 32'd0);

    // A4: first edge after reset release starts the note
    rst_n = 1'b1; key = 5'd9;
    cycle();
    chk("first_playing", 32'(playing), 32'd1);
    run(63);
    chk("a4_level_full", 32'(level), 32'd15);
    run(2400);

    // Release, then re-press at level 7
    press = 1'b0;
    n = 0;
    while (m_level != 7 && n < 200) begin cycle(); n++; end
    chk("lvl7_reached", 32'(level), 32'd7);
    press = 1'b1;
    run(4);
    chk("repress_no_drop", (level >= 4'd6) ? 32'd1 : 32'd0, 32'd1);
    run(100);
    press = 1'b0;
    run(100);
    chk("release_idle", 32'(playing), 32'd0);
    chk("release_silent", 32'(audio_out), 32'd0);

    // Glitch-free retune key 0 -> key 12 mid half-cycle
    key = 5'd0; press = 1'b1;
    run(1000);
    key = 5'd12;
    run(4000);
    press = 1'b0;
    run(100);

    // Invalid keys
    key = 5'd24; press = 1'b1;
    run(50);
    chk("invalid_idle", 32'(playing), 32'd0);
    key = 5'd3;
    run(100);
    key = 5'd31;
    run(100);
    chk("k31_release", 32'(playing), 32'd0);

    // Reset in the middle of a note
    key = 5'd7;
    run(300);
    rst_n = 1'b0;
    cycle();
    chk("midrst_audio", 32'(audio_out), 32'd0);
    chk("midrst_playing", 32'(playing), 32'd0);
    rst_n = 1'b1;

    // Random key/press activity
    for (int s = 0; s < 40; s++) begin
      key   = ($urandom_range(0, 9) < 8) ? 5'($urandom_range(0, 23)) : 5'($urandom_range(24, 31));
      press = ($urandom_range(0, 3) != 0);
`ifdef TONE_GEN_OCTAVE_EN
      octave = 2'($urandom_range(0, 3));
`endif
      rst_n = ($urandom_range(0, 19) != 0);
      cycle();
      rst_n = 1'b1;
      run($urandom_range(1, 300));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
